// File: rtl/uart_tx_fifo.sv
// Byte FIFO that drains queued bytes into the UART transmitter through the
// send_trig/send_data handshake, holding send_data stable for each frame.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int BSY_TIMEOUT = 8
) (
    input  logic                  clk_27mhz,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  tx_bsy,
    output logic                  send_trig,
    output logic [7:0]            send_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  hs_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(BSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_BSY, WAIT_DONE} state_t;

    state_t                state, state_nxt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  pop, push, hs_set, trig_nxt;

    // full/empty decode only the level register, never wr_en
    assign full  = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty = (level == '0);
    assign push  = wr_en && !full && !flush;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        trig_nxt  = 1'b0;
        hs_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !tx_bsy && !flush) begin
                    pop       = 1'b1;
                    trig_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = WAIT_BSY;
                end
            end
            WAIT_BSY: begin
                if (tx_bsy) begin
                    state_nxt = WAIT_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt_nxt == CW'(BSY_TIMEOUT)) begin
                        hs_set    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_bsy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk_27mhz) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            send_trig <= 1'b0;
            send_data <= '0;
            overflow  <= 1'b0;
            hs_err    <= 1'b0;
        end else begin
            send_trig <= trig_nxt;
            if (pop) send_data <= mem[rd_ptr];
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (flush) begin
                rd_ptr <= wr_ptr;
                level  <= '0;
            end else begin
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      level <= level + 1'b1;
                else if (pop && !push) level <= level - 1'b1;
            end
            // a new error event outranks a coincident clear
            if (wr_en && full && !flush) overflow <= 1'b1;
            else if (clr_err)            overflow <= 1'b0;
            if (hs_set)       hs_err <= 1'b1;
            else if (clr_err) hs_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a queue-based reference model plus a
// simple transmitter model driving tx_bsy.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG2  = 4;
    localparam int DEPTH       = 16;
    localparam int BSY_TIMEOUT = 8;

    localparam int TX_NORMAL = 0;
    localparam int TX_STUCK0 = 1;
    localparam int TX_HOLD   = 2;

    logic       clk_27mhz = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;
    logic       tx_bsy = 1'b0;
    logic       send_trig;
    logic [7:0] send_data;
    logic       full, empty, overflow, hs_err;
    logic [DEPTH_LOG2:0] level;

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .BSY_TIMEOUT(BSY_TIMEOUT)) dut (
        .clk_27mhz(clk_27mhz), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .flush(flush), .clr_err(clr_err), .tx_bsy(tx_bsy),
        .send_trig(send_trig), .send_data(send_data), .full(full),
        .empty(empty), .level(level), .overflow(overflow), .hs_err(hs_err)
    );

    always #18.5 clk_27mhz = ~clk_27mhz;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0] m_q[$];
    bit         m_busy, m_wait, m_ovf, m_hs, m_trig;
    int         m_cnt;
    logic [7:0] m_data;

    // transmitter model state
    int tx_mode    = TX_NORMAL;
    int frame_len  = 90;
    int frame_left = 0;
    bit rand_frame = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        int  sz;
        bit  pop, ovf_ev, hs_ev;
        if (rst) begin
            m_q.delete();
            m_busy = 0; m_wait = 0; m_cnt = 0;
            m_ovf = 0; m_hs = 0; m_trig = 0; m_data = '0;
            return;
        end
        sz     = m_q.size();
        pop    = !m_busy && sz > 0 && !tx_bsy && !flush;
        ovf_ev = wr_en && sz == DEPTH && !flush;
        hs_ev  = 0;
        m_trig = 0;
        if (m_busy) begin
            if (m_wait) begin
                if (tx_bsy) m_wait = 0;
                else begin
                    m_cnt++;
                    if (m_cnt == BSY_TIMEOUT) begin
                        hs_ev  = 1;
                        m_busy = 0;
                    end
                end
            end else if (!tx_bsy) begin
                m_busy = 0;
            end
        end
        if (flush) m_q.delete();
        else begin
            if (pop) begin
                m_data = m_q.pop_front();
                m_trig = 1; m_busy = 1; m_wait = 1; m_cnt = 0;
            end
            if (wr_en && sz < DEPTH) m_q.push_back(wr_data);
        end
        if (clr_err) begin m_ovf = 0; m_hs = 0; end
        if (ovf_ev) m_ovf = 1;
        if (hs_ev)  m_hs  = 1;
    endtask

    // one clock: model, edge, transmitter response, compare, release strobes
    task automatic step();
        bit trig_seen;
        trig_seen = send_trig;
        model_update();
        @(posedge clk_27mhz);
        #1;
        if (rst) frame_left = 0;
        else if (trig_seen) begin
            if (rand_frame) frame_len = $urandom_range(1, 12);
            frame_left = frame_len;
        end else if (frame_left > 0) frame_left--;
        tx_bsy = (tx_mode == TX_HOLD) || (tx_mode == TX_NORMAL && frame_left > 0);
        check("send_trig", 32'(send_trig), 32'(m_trig));
        check("send_data", 32'(send_data), 32'(m_data));
        check("level",     32'(level),     32'(m_q.size()));
        check("full",      32'(full),      32'(m_q.size() == DEPTH));
        check("empty",     32'(empty),     32'(m_q.size() == 0));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("hs_err",    32'(hs_err),    32'(m_hs));
        rst = 0; wr_en = 0; flush = 0; clr_err = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1; wr_data = b;
        step();
    endtask

    task automatic do_reset();
        rst = 1;
        step();
    endtask

    initial begin
        // reset state
        do_reset();
        do_reset();

        // single byte, 90-cycle frame
        tx_mode = TX_NORMAL; frame_len = 90;
        push(8'h5A);
        run(100);

        // burst ordering: fill while transmitter busy, then drain
        tx_mode = TX_HOLD; tx_bsy = 1; frame_len = 20;
        for (int i = 1; i <= 16; i++) push(8'(i));
        run(3);
        tx_mode = TX_NORMAL; tx_bsy = 0;
        run(16 * 24);

        // overflow: 16 queued then 0xFF dropped, then clear
        tx_mode = TX_HOLD; tx_bsy = 1;
        for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 254)));
        push(8'hFF);
        run(2);
        clr_err = 1; step();
        tx_mode = TX_NORMAL; tx_bsy = 0; frame_len = 6;
        run(16 * 10);

        // handshake error: tx_bsy never rises
        tx_mode = TX_STUCK0;
        push(8'hA1);
        push(8'hB2);
        run(2 * (BSY_TIMEOUT + 4));
        clr_err = 1; step();
        run(3);
        tx_mode = TX_NORMAL;

        // flush during first frame
        frame_len = 30;
        for (int i = 0; i < 5; i++) push(8'($urandom));
        run(6);
        flush = 1; step();
        run(60);

        // reset during WAIT_DONE with level 3
        frame_len = 40;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        run(8);
        do_reset();
        run(50);

        // randomized traffic
        rand_frame = 1;
        for (int c = 0; c < 6000; c++) begin
            if (c % 250 == 0) begin
                int r;
                r = $urandom_range(0, 99);
                tx_mode = (r < 85) ? TX_NORMAL : (r < 95) ? TX_STUCK0 : TX_HOLD;
                if (tx_mode != TX_NORMAL) frame_left = 0;
            end
            wr_en   = ($urandom_range(0, 99) < 40);
            wr_data = 8'($urandom);
            flush   = ($urandom_range(0, 199) == 0);
            clr_err = ($urandom_range(0, 99) == 0);
            rst     = ($urandom_range(0, 1499) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
